// File: rtl/fir_ctrl_regs.sv
// fir_ctrl_regs: register bank for the 2D FIR core (kernel, image size, control/status, IRQ).
// Latency: writes take effect on the write edge (visible next cycle); rd_data is combinational.
// Backpressure: none; accepts one write and serves one read every cycle. SIZE/COEF writes
// are dropped while the core is busy so its configuration is stable for a whole frame.
//
// Ports:
//   clk, rst_n                       clock, async active-low reset
//   wr_addr/wr_en/wr_data/wr_strb    register write port (byte address, byte enables)
//   rd_addr/rd_en/rd_data            register read port (rd_data combinational)
//   busy_i, done_i                   core status: frame in progress, frame-complete pulse
//   start_o                          one-cycle frame start pulse
//   img_width_o, img_height_o        image size
//   coef_o                           9 flattened signed coefficients, COEFk at [k*COEF_W +: COEF_W]
//   irq_o                            level interrupt = DONE & IRQ_EN
module fir_ctrl_regs #(
  parameter int          COEF_W   = 16,
  parameter logic [31:0] ID_VALUE = 32'h4649_5232
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            wr_addr,
  input  logic                  wr_en,
  input  logic [31:0]           wr_data,
  input  logic [3:0]            wr_strb,
  input  logic [7:0]            rd_addr,
  input  logic                  rd_en,
  output logic [31:0]           rd_data,
  input  logic                  busy_i,
  input  logic                  done_i,
  output logic                  start_o,
  output logic [10:0]           img_width_o,
  output logic [10:0]           img_height_o,
  output logic [9*COEF_W-1:0]   coef_o,
  output logic                  irq_o
);

  // Word indices (byte address >> 2)
  localparam logic [5:0] A_CTRL   = 6'h00;
  localparam logic [5:0] A_STATUS = 6'h01;
  localparam logic [5:0] A_SIZE   = 6'h02;
  localparam logic [5:0] A_ID     = 6'h03;
  localparam logic [5:0] A_COEF0  = 6'h10;

  logic [5:0]        waddr;
  logic [5:0]        raddr;
  logic [31:0]       wmask;
  logic              irq_en_q;
  logic              done_q;
  logic              start_q;
  logic [10:0]       width_q;
  logic [10:0]       height_q;
  logic [COEF_W-1:0] coef_q [9];
  logic              done_clr;

  assign waddr = wr_addr[7:2];
  assign raddr = rd_addr[7:2];

  // Per-bit write enable built from the byte strobes
  assign wmask = {{8{wr_strb[3]}}, {8{wr_strb[2]}}, {8{wr_strb[1]}}, {8{wr_strb[0]}}};

  assign done_clr = wr_en && (waddr == A_STATUS) && wr_strb[0] && wr_data[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_en_q <= 1'b0;
      done_q   <= 1'b0;
      start_q  <= 1'b0;
      width_q  <= '0;
      height_q <= '0;
      for (int k = 0; k < 9; k++) coef_q[k] <= '0;
    end else begin
      start_q <= 1'b0;
      // A completion arriving in the same cycle as a clear must not be lost
      done_q  <= done_i | (done_q & ~done_clr);

      if (wr_en && (waddr == A_CTRL) && wr_strb[0]) begin
        irq_en_q <= wr_data[1];
        start_q  <= wr_data[0] & ~busy_i;
      end

      if (wr_en && !busy_i && (waddr == A_SIZE)) begin
        width_q  <= (width_q  & ~wmask[10:0])  | (wr_data[10:0]  & wmask[10:0]);
        height_q <= (height_q & ~wmask[26:16]) | (wr_data[26:16] & wmask[26:16]);
      end

      for (int k = 0; k < 9; k++) begin
        if (wr_en && !busy_i && (waddr == A_COEF0 + 6'(k))) begin
          coef_q[k] <= (coef_q[k] & ~wmask[COEF_W-1:0]) | (wr_data[COEF_W-1:0] & wmask[COEF_W-1:0]);
        end
      end
    end
  end

  always_comb begin
    rd_data = '0;
    case (raddr)
      A_CTRL:   rd_data[1]   = irq_en_q;
      A_STATUS: rd_data[1:0] = {done_q, busy_i};
      A_SIZE:   rd_data      = {5'b0, height_q, 5'b0, width_q};
      A_ID:     rd_data      = ID_VALUE;
      default: begin
        for (int k = 0; k < 9; k++) begin
          if (raddr == A_COEF0 + 6'(k)) begin
            rd_data = {{(32-COEF_W){coef_q[k][COEF_W-1]}}, coef_q[k]};
          end
        end
      end
    endcase
  end

  for (genvar k = 0; k < 9; k++) begin : g_coef
    assign coef_o[k*COEF_W +: COEF_W] = coef_q[k];
  end

  assign start_o      = start_q;
  assign img_width_o  = width_q;
  assign img_height_o = height_q;
  assign irq_o        = done_q & irq_en_q;

  // Inputs/bits with no function in this block (no read side effects, word-aligned map)
  logic unused_bits;
  assign unused_bits = ^{rd_en, wr_addr[1:0], rd_addr[1:0], wr_data[31:27], wmask[31:27]};

endmodule
